// File: rtl/dm_cache_mem_model.sv
// Main-memory responder for the direct-mapped cache: accepts one line request
// at a time and returns a 128-bit line with a one-cycle ready pulse LATENCY cycles later.

package dm_cache_mem_pkg;
   typedef struct packed {
      logic [31:0]  addr;
      logic [127:0] data;
      logic         rw;
      logic         valid;
   } mem_req_type;

   typedef struct packed {
      logic [127:0] data;
      logic         ready;
   } mem_data_type;
endpackage

// state  | meaning
// S_IDLE | no request outstanding, accepts valid
// S_BUSY | request accepted, counting down latency, valids are dropped
// S_RESP | ready pulse cycle; a valid here is accepted as from S_IDLE
module dm_cache_mem_model
   import dm_cache_mem_pkg::*;
#(
   parameter int LINES_LOG2 = 12,
   parameter int LATENCY    = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  mem_req_type  mem_req,
   output mem_data_type mem_data,
   output logic         busy,
   output logic         drop_err
);

   localparam int          LINES  = 1 << LINES_LOG2;
   localparam logic [7:0]  LAT_M1 = 8'(LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [7:0]              r_cnt;
   logic [7:0]              w_cnt_nxt;
   logic [127:0]            r_mem [LINES];
   logic [127:0]            r_resp_data;
   logic [127:0]            r_out_data;
   logic                    r_drop_err;

   logic [LINES_LOG2-1:0]   w_idx;
   logic                    w_accept;
   logic                    w_drop;
   logic                    w_tc;
   logic [127:0]            w_line;
   logic                    w_unused;

   assign w_idx    = mem_req.addr[LINES_LOG2+3:4];
   assign w_accept = mem_req.valid && (r_state != S_BUSY);
   assign w_drop   = mem_req.valid && (r_state == S_BUSY);
   assign w_line   = mem_req.rw ? mem_req.data : r_mem[w_idx];
   // Counter is loaded with LATENCY-1 and hits zero on the edge that enters S_RESP.
   assign w_tc     = (r_cnt == 8'd1);
   assign w_unused = ^{mem_req.addr[31:LINES_LOG2+4], mem_req.addr[3:0]};

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE, S_RESP: begin
            if (w_accept) begin
               w_cnt_nxt   = LAT_M1;
               w_state_nxt = (LATENCY == 1) ? S_RESP : S_BUSY;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_BUSY: begin
            w_cnt_nxt = r_cnt - 8'd1;
            if (w_tc) begin
               w_state_nxt = S_RESP;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 8'd0;
         r_resp_data <= '0;
         r_out_data  <= '0;
         r_drop_err  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_resp_data <= w_line;
         end
         // Output data only changes on entry to the ready cycle and holds afterwards.
         if (w_state_nxt == S_RESP) begin
            r_out_data <= (r_state == S_BUSY) ? r_resp_data : w_line;
         end
         if (w_drop) begin
            r_drop_err <= 1'b1;
         end
      end
   end

   // The line array has no reset; contents survive rst.
   always_ff @(posedge clk) begin
      if (rst && w_accept && mem_req.rw) begin
         r_mem[w_idx] <= mem_req.data;
      end
   end

   assign mem_data.ready = (r_state == S_RESP);
   assign mem_data.data  = r_out_data;
   assign busy           = (r_state == S_BUSY);
   assign drop_err       = r_drop_err;

endmodule

// File: tb/tb_dm_cache_mem_model.sv
// Scoreboard bench for dm_cache_mem_model: a line-indexed reference memory predicts
// each response's data and arrival cycle; a negedge monitor checks what the DUT presents.

module tb_dm_cache_mem_model;
   import dm_cache_mem_pkg::*;

   localparam int L   = 4;
   localparam int LL2 = 12;
   localparam logic [127:0] PAT_A = {32{4'hA}};
   localparam logic [127:0] PAT_5 = {32{4'h5}};

   logic         clk = 1'b0;
   logic         rst;
   mem_req_type  mem_req;
   mem_data_type mem_data;
   logic         busy;
   logic         drop_err;

   dm_cache_mem_model #(.LINES_LOG2(LL2), .LATENCY(L)) dut (
      .clk      (clk),
      .rst      (rst),
      .mem_req  (mem_req),
      .mem_data (mem_data),
      .busy     (busy),
      .drop_err (drop_err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int pcnt     = 0;

   always @(posedge clk) pcnt <= pcnt + 1;

   typedef struct {
      int           t;
      logic [127:0] data;
   } exp_t;

   exp_t         sb[$];
   logic [127:0] ref_mem [int];
   logic [31:0]  known[$];

   function automatic int line_of(input logic [31:0] a);
      return int'((a >> 4) % (32'd1 << LL2));
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, pcnt);
      end
   endtask

   // Monitor: busy must be high strictly between acceptance and the ready cycle.
   always @(negedge clk) begin : mon
      bit   eb;
      exp_t e;
      eb = 1'b0;
      foreach (sb[i]) begin
         if (pcnt >= sb[i].t - L + 1 && pcnt <= sb[i].t - 1) eb = 1'b1;
      end
      check("busy", {127'd0, busy}, {127'd0, eb});
      if (mem_data.ready) begin
         if (sb.size() == 0) begin
            check("ready_when_none_pending", {127'd0, mem_data.ready}, 128'd0);
         end else begin
            e = sb.pop_front();
            check("ready_time", 128'(pcnt), 128'(e.t));
            check("ready_data", mem_data.data, e.data);
         end
      end
   end

   // Called at a negedge; the request is sampled at the following posedge.
   task automatic send(input bit rw, input logic [31:0] a, input logic [127:0] d, input bit accepted);
      exp_t e;
      int   idx;
      idx           = line_of(a);
      mem_req.valid = 1'b1;
      mem_req.rw    = rw;
      mem_req.addr  = a;
      mem_req.data  = d;
      if (accepted) begin
         if (rw) ref_mem[idx] = d;
         e.t    = pcnt + L;
         e.data = ref_mem[idx];
         sb.push_back(e);
      end
      @(negedge clk);
      mem_req.valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", 128'(sb.size()), 128'd0);
      sb.delete();
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, {127'd0, mem_data.ready}, 128'd0);
      check({tag, "_data"}, mem_data.data, 128'd0);
      check({tag, "_busy"}, {127'd0, busy}, 128'd0);
      check({tag, "_drop_err"}, {127'd0, drop_err}, 128'd0);
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      logic [127:0] d;
      logic [31:0]  a;
      logic [31:0]  r;
      bit           rw;
      rst     = 1'b0;
      mem_req = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;
      @(negedge clk);

      // Write then read with different offset bits
      send(1'b1, 32'h0000_1230, PAT_A, 1'b1);
      wait_idle();
      send(1'b0, 32'h0000_1234, rand128(), 1'b1);
      wait_idle();

      // Write-back then fill issued in the ready cycle
      send(1'b1, 32'h0000_0080, rand128(), 1'b1);
      wait_idle();
      send(1'b1, 32'h0000_0040, rand128(), 1'b1);
      repeat (L - 1) @(negedge clk);
      send(1'b0, 32'h0000_0080, rand128(), 1'b1);
      wait_idle();
      check("chain_no_drop", {127'd0, drop_err}, 128'd0);

      // Valid during BUSY is dropped and the line keeps its old value
      send(1'b1, 32'h0000_0300, rand128(), 1'b1);
      wait_idle();
      send(1'b1, 32'h0000_0200, rand128(), 1'b1);
      send(1'b1, 32'h0000_0300, rand128(), 1'b0);
      wait_idle();
      check("drop_set", {127'd0, drop_err}, 128'd1);
      send(1'b0, 32'h0000_0300, rand128(), 1'b1);
      wait_idle();
      check("drop_sticky", {127'd0, drop_err}, 128'd1);

      // Address bits above the index alias
      send(1'b1, 32'h0000_0010, PAT_5, 1'b1);
      wait_idle();
      send(1'b0, 32'h0001_0010, rand128(), 1'b1);
      wait_idle();

      // Random traffic with gaps of 0..2 cycles after each ready
      for (int i = 0; i < 40; i++) begin
         r  = $urandom;
         rw = (known.size() == 0) || ($urandom_range(0, 1) == 1);
         if (rw) begin
            a = r;
            known.push_back(a);
         end else begin
            a = (known[$urandom_range(0, known.size() - 1)] & 32'h0000_FFF0) | (r & 32'hFFFF_000F);
         end
         send(rw, a, rand128(), 1'b1);
         repeat (L - 1) @(negedge clk);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle();
      check("drop_sticky_end", {127'd0, drop_err}, 128'd1);

      // Reset mid-read: no ready; array contents survive
      d = rand128();
      send(1'b1, 32'h0000_07F0, d, 1'b1);
      wait_idle();
      send(1'b0, 32'h0000_07F0, rand128(), 1'b1);
      repeat (L - 2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      sb.delete();
      repeat (2) @(negedge clk);
      check_reset_outputs("midop_reset");
      rst = 1'b1;
      @(negedge clk);

      // Reset right after a write is accepted: the write still commits
      send(1'b1, 32'h0000_0900, rand128(), 1'b1);
      rst = 1'b0;
      @(posedge clk);
      sb.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      send(1'b0, 32'h0000_07F4, rand128(), 1'b1);
      wait_idle();
      send(1'b0, 32'h0000_0900, rand128(), 1'b1);
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
